// File: rtl/muxin_scanner.sv
// muxin_scanner: scans NUM_CH slow input channels, publishing one (value, id) pair per
// interface sync rising edge, and runs the interface-timeout watchdog.
//
// Ports:
//   clk        system clock (sysclk)
//   rst_n      asynchronous active-low reset, released synchronously upstream
//   sync       raw interface sync, asynchronous to clk
//   ch_data    channel i at [i*WIDTH +: WIDTH]
//   ch_enable  1 = channel takes part in the scan
//   mux_value  published channel value
//   mux_id     index of the published channel
//   mux_valid  1 = mux_value/mux_id hold a scanned channel
//   edge_pulse one-clock pulse per detected sync rising edge
//   timeout    interface watchdog expired
//
// Optional feature: define MUXIN_CHANGE_PRIORITY_EN to let channels whose value differs
// from the last published value jump the round-robin queue (lowest index first).
module muxin_scanner #(
    parameter int NUM_CH  = 2,
    parameter int WIDTH   = 16,
    parameter int ID_W    = 8,
    parameter int TIMEOUT = 2700000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sync,
    input  logic [NUM_CH*WIDTH-1:0] ch_data,
    input  logic [NUM_CH-1:0]       ch_enable,
    output logic [WIDTH-1:0]        mux_value,
    output logic [ID_W-1:0]         mux_id,
    output logic                    mux_valid,
    output logic                    edge_pulse,
    output logic                    timeout
);
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    logic [2:0]       sr;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    nxt;
    logic             any;
    logic [WIDTH-1:0] ch [NUM_CH];

    genvar g;
    for (g = 0; g < NUM_CH; g++) begin : g_ch
        assign ch[g] = ch_data[g*WIDTH +: WIDTH];
    end

`ifdef MUXIN_CHANGE_PRIORITY_EN
    logic [WIDTH-1:0] last_sent [NUM_CH];
`endif

    // Round-robin search starting after mux_id; the descending loop lets the
    // nearest enabled channel win. mux_id itself is the last candidate.
    always_comb begin
        nxt = IW'(mux_id);
        any = 1'b0;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (ch_enable[IW'((int'(mux_id) + k) % NUM_CH)]) begin
                any = 1'b1;
                nxt = IW'((int'(mux_id) + k) % NUM_CH);
            end
        end
`ifdef MUXIN_CHANGE_PRIORITY_EN
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_enable[i] && (ch[i] != last_sent[i])) begin
                any = 1'b1;
                nxt = IW'(i);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr         <= '0;
            edge_pulse <= 1'b0;
            cnt        <= '0;
            timeout    <= 1'b0;
            mux_value  <= '0;
            mux_id     <= ID_W'(NUM_CH - 1);
            mux_valid  <= 1'b0;
        end else begin
            sr         <= {sr[1:0], sync};
            edge_pulse <= (sr[2:1] == 2'b01);
            // An edge clears the watchdog even when it is saturated.
            cnt        <= edge_pulse ? '0 : ((cnt < TMAX) ? cnt + 1'b1 : cnt);
            timeout    <= (cnt >= TMAX) && !edge_pulse;
            if (edge_pulse) begin
                mux_id    <= any ? ID_W'(nxt) : mux_id;
                mux_value <= any ? ch[nxt] : '0;
                mux_valid <= any;
            end
        end
    end

`ifdef MUXIN_CHANGE_PRIORITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) last_sent[i] <= '0;
        end else if (edge_pulse && any) begin
            last_sent[nxt] <= ch[nxt];
        end
    end
`endif
endmodule

// File: tb/tb_muxin_scanner.sv
// tb_muxin_scanner: directed self-checking bench for muxin_scanner (NUM_CH=4, TIMEOUT=10).
module tb_muxin_scanner;
    logic        sysclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync = 1'b0;
    logic [63:0] ch_data = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
    logic [3:0]  ch_enable = 4'hF;
    logic [15:0] mux_value;
    logic [7:0]  mux_id;
    logic        mux_valid;
    logic        edge_pulse;
    logic        timeout;
    int          n_cmp = 0;
    int          n_bad = 0;

    muxin_scanner #(.NUM_CH(4), .WIDTH(16), .ID_W(8), .TIMEOUT(10)) dut (
        .clk(sysclk), .rst_n(rst_n), .sync(sync), .ch_data(ch_data), .ch_enable(ch_enable),
        .mux_value(mux_value), .mux_id(mux_id), .mux_valid(mux_valid),
        .edge_pulse(edge_pulse), .timeout(timeout)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        rst_n = 1'b0;
        sync = 1'b0;
        @(negedge sysclk);
        rst_n = 1'b1;
    endtask

    // Raise sync, expect edge_pulse on the 3rd clock, then the selection one clock later.
    task automatic pulse(input string tag, input logic [7:0] eid, input logic [15:0] ev,
                         input logic eok);
        int n;
        n = 0;
        @(negedge sysclk);
        sync = 1'b1;
        while (!edge_pulse && n < 8) begin
            @(negedge sysclk);
            n++;
        end
        check({tag, "_lat"}, 32'(n), 3);
        @(negedge sysclk);
        check({tag, "_ep"}, 32'(edge_pulse), 0);
        check({tag, "_id"}, 32'(mux_id), 32'(eid));
        check({tag, "_val"}, 32'(mux_value), 32'(ev));
        check({tag, "_vld"}, 32'(mux_valid), 32'(eok));
        sync = 1'b0;
        repeat (4) @(negedge sysclk);
    endtask

    initial begin
        // T1 reset state
        repeat (3) @(negedge sysclk);
        check("rst_id", 32'(mux_id), 3);
        check("rst_vld", 32'(mux_valid), 0);
        check("rst_val", 32'(mux_value), 0);
        check("rst_to", 32'(timeout), 0);
        check("rst_ep", 32'(edge_pulse), 0);

        // T4 watchdog
        rst_n = 1'b1;
        repeat (10) @(negedge sysclk);
        check("to_c10", 32'(timeout), 0);
        @(negedge sysclk);
        check("to_c11", 32'(timeout), 1);
        sync = 1'b1;
        repeat (3) @(negedge sysclk);
        check("to_ep", 32'(edge_pulse), 1);
        check("to_at_ep", 32'(timeout), 1);
        @(negedge sysclk);
        sync = 1'b0;
        check("to_clr", 32'(timeout), 0);
        repeat (10) @(negedge sysclk);
        check("to_re10", 32'(timeout), 0);
        @(negedge sysclk);
        check("to_re11", 32'(timeout), 1);

        // T2 round-robin
        do_reset();
        pulse("rr0", 8'd0, 16'h000A, 1'b1);
        pulse("rr1", 8'd1, 16'h000B, 1'b1);
        pulse("rr2", 8'd2, 16'h000C, 1'b1);
        pulse("rr3", 8'd3, 16'h000D, 1'b1);
        pulse("rr4", 8'd0, 16'h000A, 1'b1);

        // T3 enable mask
        do_reset();
        ch_enable = 4'b1010;
        pulse("mk0", 8'd1, 16'h000B, 1'b1);
        pulse("mk1", 8'd3, 16'h000D, 1'b1);
        pulse("mk2", 8'd1, 16'h000B, 1'b1);
        pulse("mk3", 8'd3, 16'h000D, 1'b1);
        ch_enable = 4'b0000;
        pulse("mk_none", 8'd3, 16'h0000, 1'b0);
        ch_enable = 4'hF;

        // T5 change priority vs. plain rotation
        do_reset();
        pulse("pr0", 8'd0, 16'h000A, 1'b1);
        pulse("pr1", 8'd1, 16'h000B, 1'b1);
        pulse("pr2", 8'd2, 16'h000C, 1'b1);
        pulse("pr3", 8'd3, 16'h000D, 1'b1);
        ch_data[47:32] = 16'h1234;
`ifdef MUXIN_CHANGE_PRIORITY_EN
        pulse("pr_chg", 8'd2, 16'h1234, 1'b1);
        pulse("pr_rr", 8'd3, 16'h000D, 1'b1);
`else
        pulse("pr_chg", 8'd0, 16'h000A, 1'b1);
        pulse("pr_rr", 8'd1, 16'h000B, 1'b1);
`endif
        ch_data[47:32] = 16'h000C;

        // T6 asynchronous reset mid-scan
        do_reset();
        pulse("ar0", 8'd0, 16'h000A, 1'b1);
        pulse("ar1", 8'd1, 16'h000B, 1'b1);
        @(negedge sysclk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_id", 32'(mux_id), 3);
        check("ar_vld", 32'(mux_valid), 0);
        check("ar_val", 32'(mux_value), 0);
        check("ar_to", 32'(timeout), 0);
        @(negedge sysclk);
        rst_n = 1'b1;
        pulse("ar_post", 8'd0, 16'h000A, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
